// File: rtl/round_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : round_unit_arbiter
// Purpose  : Round-robin share of one external rounder across NREQ producers,
//            with a registered issue stage and a registered tagged result stage.
//            Optional macro ROUND_UNIT_ARB_PRIO0_EN gives requester 0 absolute priority.
// Revision : 1.0  initial release
// ============================================================================
module round_unit_arbiter #(
  parameter int NREQ = 3,
  parameter int TAGW = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*79-1:0]   req_bits,
  output logic [78:0]          rnd_bits,
  input  logic [64:0]          rnd_out,
  input  logic [4:0]           rnd_flags,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [64:0]          resp_out,
  output logic [4:0]           resp_flags,
  output logic [TAGW-1:0]      resp_tag,
  output logic                 idle
);

  localparam int BITS_W = 79;

  logic                a_valid_q, a_valid_d;
  logic [BITS_W-1:0]   a_bits_q,  a_bits_d;
  logic [TAGW-1:0]     a_tag_q,   a_tag_d;
  logic                b_valid_q, b_valid_d;
  logic [64:0]         b_out_q,   b_out_d;
  logic [4:0]          b_flags_q, b_flags_d;
  logic [TAGW-1:0]     b_tag_q,   b_tag_d;
  logic [TAGW-1:0]     ptr_q,     ptr_d;

  logic                w_b_load;
  logic                w_a_free;
  logic                w_found;
  logic                w_hs;
  logic [TAGW-1:0]     w_gnt_idx;
  logic [NREQ-1:0]     w_grant;
  int                  w_idx;

  assign w_b_load = a_valid_q & (~b_valid_q | resp_ready);
  assign w_a_free = ~a_valid_q | w_b_load;

  // Search starts one past the last winner and wraps; the first requester found wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
`ifdef ROUND_UNIT_ARB_PRIO0_EN
    if (req_valid[0]) begin
      w_found   = 1'b1;
      w_gnt_idx = '0;
    end
`endif
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(ptr_q) + k) % NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = TAGW'(w_idx);
      end
    end
  end

  // reset gates the grant so req_ready stays low while the block is held in reset
  assign w_hs = w_found & w_a_free & ~flush & reset;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_grant[i] = w_hs & (w_gnt_idx == TAGW'(i));
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_bits_d  = a_bits_q;
    a_tag_d   = a_tag_q;
    ptr_d     = ptr_q;
    if (flush) begin
      a_valid_d = 1'b0;
    end else if (w_hs) begin
      a_valid_d = 1'b1;
      a_bits_d  = req_bits[BITS_W*int'(w_gnt_idx) +: BITS_W];
      a_tag_d   = w_gnt_idx;
`ifdef ROUND_UNIT_ARB_PRIO0_EN
      if (w_gnt_idx != '0) ptr_d = w_gnt_idx;
`else
      ptr_d     = w_gnt_idx;
`endif
    end else if (w_a_free) begin
      a_valid_d = 1'b0;
    end
  end

  always_comb begin
    b_valid_d = b_valid_q;
    b_out_d   = b_out_q;
    b_flags_d = b_flags_q;
    b_tag_d   = b_tag_q;
    if (w_b_load) begin
      b_valid_d = 1'b1;
      b_out_d   = rnd_out;
      b_flags_d = rnd_flags;
      b_tag_d   = a_tag_q;
    end else if (resp_ready) begin
      b_valid_d = 1'b0;
    end
    if (flush) b_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_valid_q <= 1'b0;
      a_bits_q  <= '0;
      a_tag_q   <= '0;
      b_valid_q <= 1'b0;
      b_out_q   <= '0;
      b_flags_q <= '0;
      b_tag_q   <= '0;
      ptr_q     <= TAGW'(NREQ - 1);
    end else begin
      a_valid_q <= a_valid_d;
      a_bits_q  <= a_bits_d;
      a_tag_q   <= a_tag_d;
      b_valid_q <= b_valid_d;
      b_out_q   <= b_out_d;
      b_flags_q <= b_flags_d;
      b_tag_q   <= b_tag_d;
      ptr_q     <= ptr_d;
    end
  end

  assign req_ready  = w_grant;
  assign rnd_bits   = a_bits_q;
  assign resp_valid = b_valid_q;
  assign resp_out   = b_out_q;
  assign resp_flags = b_flags_q;
  assign resp_tag   = b_tag_q;
  assign idle       = ~a_valid_q & ~b_valid_q;

endmodule
`default_nettype wire
